// File: rtl/demux_l2_sched.sv
// demux_l2_sched: strict round-robin byte striping over enabled lanes with per-lane pause stall.
module demux_l2_sched (
   input  logic       clk_4f,
   input  logic       reset,
   input  logic [7:0] Entrada,
   input  logic       validEntrada,
   input  logic [3:0] lane_enable,
   input  logic [3:0] fifo_pause,
   output logic       ready,
   output logic [7:0] Salida0,
   output logic [7:0] Salida1,
   output logic [7:0] Salida2,
   output logic [7:0] Salida3,
   output logic       validSalida0,
   output logic       validSalida1,
   output logic       validSalida2,
   output logic       validSalida3,
   output logic [1:0] selector,
   output logic       stall,
   output logic [7:0] stripe_count
);
   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;
   state_t     state_q, state_d;
   logic [3:0] mask_q, mask_d;
   logic [1:0] sel_q, sel_d;
   logic [7:0] stripe_q, stripe_d;
   logic [7:0] sal_q [4];
   logic [3:0] vld_q;
   logic       accept, has_next;
   logic [1:0] next_sel, low_en;

   // Descending scan leaves the lowest qualifying index in each result.
   always_comb begin
      has_next = 1'b0;
      next_sel = sel_q;
      low_en   = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (mask_q[i] && i > int'(sel_q)) begin
            has_next = 1'b1;
            next_sel = i[1:0];
         end
         if (lane_enable[i]) low_en = i[1:0];
      end
   end

   always_comb begin
      ready  = (state_q == RUN) && !fifo_pause[sel_q];
      accept = ready && validEntrada;
      stall  = (state_q == STALL);
   end

   always_comb begin
      state_d  = state_q;
      mask_d   = mask_q;
      sel_d    = sel_q;
      stripe_d = stripe_q;
      case (state_q)
         IDLE: begin
            mask_d = lane_enable;
            if (|lane_enable) begin
               state_d = RUN;
               sel_d   = low_en;
            end
         end
         RUN: begin
            if (fifo_pause[sel_q]) state_d = STALL;
            else if (accept) begin
               if (has_next) sel_d = next_sel;
               else begin
                  stripe_d = stripe_q + 8'd1;
                  mask_d   = lane_enable;
                  if (|lane_enable) sel_d = low_en;
                  else state_d = IDLE;
               end
            end
         end
         STALL: state_d = fifo_pause[sel_q] ? STALL : RUN;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_4f or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         mask_q   <= 4'd0;
         sel_q    <= 2'd0;
         stripe_q <= 8'd0;
         vld_q    <= 4'd0;
         for (int i = 0; i < 4; i++) sal_q[i] <= 8'd0;
      end else begin
         state_q  <= state_d;
         mask_q   <= mask_d;
         sel_q    <= sel_d;
         stripe_q <= stripe_d;
         vld_q    <= accept ? (4'b0001 << sel_q) : 4'd0;
         for (int i = 0; i < 4; i++)
            if (accept && int'(sel_q) == i) sal_q[i] <= Entrada;
      end
   end

   assign Salida0      = sal_q[0];
   assign Salida1      = sal_q[1];
   assign Salida2      = sal_q[2];
   assign Salida3      = sal_q[3];
   assign validSalida0 = vld_q[0];
   assign validSalida1 = vld_q[1];
   assign validSalida2 = vld_q[2];
   assign validSalida3 = vld_q[3];
   assign selector     = sel_q;
   assign stripe_count = stripe_q;
endmodule

// File: tb/tb_demux_l2_sched.sv
// tb_demux_l2_sched: directed vectors with hand-computed lane/order expectations.
module tb_demux_l2_sched;
   logic       clk_4f = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] Entrada = 8'd0;
   logic       validEntrada = 1'b0;
   logic [3:0] lane_enable = 4'd0;
   logic [3:0] fifo_pause = 4'd0;
   logic       ready, stall;
   logic [7:0] Salida0, Salida1, Salida2, Salida3, stripe_count;
   logic       validSalida0, validSalida1, validSalida2, validSalida3;
   logic [1:0] selector;
   logic [7:0] sal [4];
   logic [3:0] vs;
   int         errors = 0;
   int         checks = 0;

   demux_l2_sched dut (
      .clk_4f(clk_4f), .reset(reset), .Entrada(Entrada), .validEntrada(validEntrada),
      .lane_enable(lane_enable), .fifo_pause(fifo_pause), .ready(ready),
      .Salida0(Salida0), .Salida1(Salida1), .Salida2(Salida2), .Salida3(Salida3),
      .validSalida0(validSalida0), .validSalida1(validSalida1),
      .validSalida2(validSalida2), .validSalida3(validSalida3),
      .selector(selector), .stall(stall), .stripe_count(stripe_count)
   );

   always #5 clk_4f = ~clk_4f;

   assign sal[0] = Salida0;
   assign sal[1] = Salida1;
   assign sal[2] = Salida2;
   assign sal[3] = Salida3;
   assign vs = {validSalida3, validSalida2, validSalida1, validSalida0};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_4f);
      #1;
   endtask

   task automatic do_reset(input logic [3:0] en);
      reset = 1'b0;
      lane_enable = en;
      validEntrada = 1'b0;
      fifo_pause = 4'd0;
      #1;
      chk("rst_sal", {Salida3, Salida2, Salida1, Salida0}, 32'd0);
      chk("rst_vs", vs, 0);
      chk("rst_sel", selector, 0);
      chk("rst_stripe", stripe_count, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ready", ready, 0);
      @(negedge clk_4f);
      reset = 1'b1;
      tick();
      chk("idle_vs", vs, 0);
   endtask

   task automatic send(input logic [7:0] b, input logic [1:0] lane);
      Entrada = b;
      validEntrada = 1'b1;
      #1;
      chk("send_ready", ready, 1);
      chk("send_sel", selector, lane);
      tick();
      chk("send_vs", vs, 4'b0001 << lane);
      chk("send_sal", sal[lane], b);
   endtask

   initial begin
      do_reset(4'b1111);
      chk("t1_sel", selector, 0);
      for (int k = 1; k <= 8; k++) send(k[7:0], 2'((k - 1) % 4));
      validEntrada = 1'b0;
      chk("t1_stripe", stripe_count, 2);

      do_reset(4'b0101);
      send(8'h10, 0);
      send(8'h11, 2);
      send(8'h12, 0);
      send(8'h13, 2);
      validEntrada = 1'b0;
      chk("t2_stripe", stripe_count, 2);

      do_reset(4'b1111);
      send(8'h20, 0);
      send(8'h21, 1);
      Entrada = 8'h22;
      fifo_pause = 4'b0100;
      #1;
      chk("t3_ready_comb", ready, 0);
      repeat (3) begin
         tick();
         chk("t3_stall", stall, 1);
         chk("t3_ready", ready, 0);
         chk("t3_vs", vs, 0);
      end
      fifo_pause = 4'd0;
      #1;
      chk("t3_ready_exit", ready, 0);
      tick();
      chk("t3_exit_vs", vs, 0);
      chk("t3_exit_stall", stall, 0);
      send(8'h22, 2);
      send(8'h23, 3);
      validEntrada = 1'b0;
      chk("t3_stripe", stripe_count, 1);

      do_reset(4'b1111);
      send(8'h30, 0);
      send(8'h31, 1);
      lane_enable = 4'b0011;
      send(8'h32, 2);
      send(8'h33, 3);
      send(8'h34, 0);
      send(8'h35, 1);
      validEntrada = 1'b0;
      chk("t4_stripe", stripe_count, 2);
      chk("t4_sel", selector, 0);

      do_reset(4'b0000);
      Entrada = 8'h99;
      validEntrada = 1'b1;
      repeat (2) begin
         tick();
         chk("t5_idle_ready", ready, 0);
         chk("t5_idle_vs", vs, 0);
      end
      lane_enable = 4'b1000;
      tick();
      chk("t5_sel", selector, 3);
      send(8'h40, 3);
      chk("t5_stripe1", stripe_count, 1);
      send(8'h41, 3);
      chk("t5_stripe2", stripe_count, 2);
      lane_enable = 4'b0000;
      send(8'h42, 3);
      chk("t5_stripe3", stripe_count, 3);
      chk("t5_idle_after", ready, 0);
      tick();
      chk("t5_no_vs", vs, 0);

      do_reset(4'b1111);
      send(8'h50, 0);
      send(8'h51, 1);
      Entrada = 8'h52;
      validEntrada = 1'b1;
      #1;
      chk("t6_sel_before", selector, 2);
      do_reset(4'b0110);
      chk("t6_sel_after", selector, 1);
      send(8'h52, 1);
      validEntrada = 1'b0;
      chk("t6_stripe", stripe_count, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
